// File: rtl/l2_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_arbiter_pkg
// Description : Shared command/source encodings and defaults for the L2 port.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_request_arbiter_pkg;

    localparam int ADDR_W_DEF = 26;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic {
        SRC_DATA  = 1'b0,
        SRC_INSTR = 1'b1
    } src_e;

    // Only read and write commands occupy a FIFO slot; idle and reserved never do.
    function automatic logic is_request(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_arbiter_if
// Description : Requester command ports and L2 valid/ready handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface l2_request_arbiter_if #(
    parameter int ADDR_W = 26
);
    logic [1:0]        d_cmd;
    logic [ADDR_W-1:0] d_add;
    logic              d_full;
    logic [1:0]        i_cmd;
    logic [ADDR_W-1:0] i_add;
    logic              i_full;
    logic              l2_valid;
    logic [1:0]        l2_cmd;
    logic [ADDR_W-1:0] l2_add;
    logic              l2_src;
    logic              l2_ready;

    modport master (
        output d_cmd, d_add, i_cmd, i_add, l2_ready,
        input  d_full, i_full, l2_valid, l2_cmd, l2_add, l2_src
    );

    modport slave (
        input  d_cmd, d_add, i_cmd, i_add, l2_ready,
        output d_full, i_full, l2_valid, l2_cmd, l2_add, l2_src
    );
endinterface
`default_nettype wire

// File: rtl/l2_request_arbiter_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : req_fifo
// Description : Per-requester command FIFO; full derives from registered count.
// Revision    : 1.0 - initial release
// ============================================================================
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_full_count = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == c_full_count);
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so natural overflow wraps them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/l2_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_arbiter
// Description : Round-robin arbiter of D/I cache requests onto one L2 port.
//               Optional grant/stall counters when ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              reset,
    l2_request_arbiter_if.slave    bus
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]            d_grants,
    output logic [31:0]            i_grants,
    output logic [31:0]            stall_cycles
`endif
);
    localparam int ENTRY_W = 2 + ADDR_W;

    logic [ENTRY_W-1:0] w_d_dout;
    logic [ENTRY_W-1:0] w_i_dout;
    logic               w_d_full;
    logic               w_i_full;
    logic               w_d_empty;
    logic               w_i_empty;
    logic               w_d_push;
    logic               w_i_push;
    logic               w_d_pop;
    logic               w_i_pop;
    logic               w_load;
    logic               w_take_i;
    logic               w_any;

    logic               r_valid;
    logic [1:0]         r_cmd;
    logic [ADDR_W-1:0]  r_add;
    logic               r_src;
    logic               r_last;

    assign w_d_push = is_request(bus.d_cmd) && !w_d_full;
    assign w_i_push = is_request(bus.i_cmd) && !w_i_full;

    req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_d_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_d_push),
        .pop   (w_d_pop),
        .din   ({bus.d_cmd, bus.d_add}),
        .dout  (w_d_dout),
        .full  (w_d_full),
        .empty (w_d_empty)
    );

    req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_i_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_i_push),
        .pop   (w_i_pop),
        .din   ({bus.i_cmd, bus.i_add}),
        .dout  (w_i_dout),
        .full  (w_i_full),
        .empty (w_i_empty)
    );

    // Instruction side wins when it is the only one ready, or on a tie after a data grant.
    assign w_load   = !r_valid || bus.l2_ready;
    assign w_any    = !w_d_empty || !w_i_empty;
    assign w_take_i = !w_i_empty && (w_d_empty || (r_last == SRC_DATA));
    assign w_d_pop  = w_load && !w_d_empty && !w_take_i;
    assign w_i_pop  = w_load && w_take_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_cmd   <= CMD_IDLE;
            r_add   <= '0;
            r_src   <= SRC_DATA;
            r_last  <= SRC_INSTR;
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                if (w_take_i) begin
                    r_cmd  <= w_i_dout[ENTRY_W-1 -: 2];
                    r_add  <= w_i_dout[ADDR_W-1:0];
                    r_src  <= SRC_INSTR;
                    r_last <= SRC_INSTR;
                end else begin
                    r_cmd  <= w_d_dout[ENTRY_W-1 -: 2];
                    r_add  <= w_d_dout[ADDR_W-1:0];
                    r_src  <= SRC_DATA;
                    r_last <= SRC_DATA;
                end
            end else begin
                r_valid <= 1'b0;
                r_cmd   <= CMD_IDLE;
                r_add   <= '0;
            end
        end
    end

    assign bus.d_full   = w_d_full;
    assign bus.i_full   = w_i_full;
    assign bus.l2_valid = r_valid;
    assign bus.l2_cmd   = r_cmd;
    assign bus.l2_add   = r_add;
    assign bus.l2_src   = r_src;

`ifdef ARB_STATS_EN
    logic w_xfer;
    logic w_stall;

    assign w_xfer  = r_valid && bus.l2_ready;
    assign w_stall = r_valid && !bus.l2_ready;

    // All three counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_grants     <= '0;
            i_grants     <= '0;
            stall_cycles <= '0;
        end else begin
            if (w_xfer && (r_src == SRC_DATA) && (d_grants != 32'hFFFF_FFFF)) begin
                d_grants <= d_grants + 32'd1;
            end
            if (w_xfer && (r_src == SRC_INSTR) && (i_grants != 32'hFFFF_FFFF)) begin
                i_grants <= i_grants + 32'd1;
            end
            if (w_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_request_arbiter
// Description : Directed self-checking bench for l2_request_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 26;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    l2_request_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef ARB_STATS_EN
    logic [31:0] d_grants;
    logic [31:0] i_grants;
    logic [31:0] stall_cycles;
`endif

    l2_request_arbiter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave)
`ifdef ARB_STATS_EN
        ,
        .d_grants     (d_grants),
        .i_grants     (i_grants),
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [1:0]  held_cmd;
    logic [25:0] held_add;

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        reset        = 1'b1;
        bus.d_cmd    = 2'b00;
        bus.d_add    = '0;
        bus.i_cmd    = 2'b00;
        bus.i_add    = '0;
        bus.l2_ready = 1'b0;

        // Reset to idle
        do_reset();
        repeat (5) step();
        check("idle_valid", {31'd0, bus.l2_valid}, 32'd0);
        check("idle_cmd",   {30'd0, bus.l2_cmd},   32'd0);
        check("idle_add",   {6'd0,  bus.l2_add},   32'd0);
        check("idle_src",   {31'd0, bus.l2_src},   32'd0);
        check("idle_dfull", {31'd0, bus.d_full},   32'd0);
        check("idle_ifull", {31'd0, bus.i_full},   32'd0);

        // Single read: visible after edge N+1, gone after N+2
        bus.l2_ready = 1'b1;
        bus.d_cmd    = 2'b01;
        bus.d_add    = 26'h0ABCDE;
        step();
        bus.d_cmd = 2'b00;
        check("rd_n_valid", {31'd0, bus.l2_valid}, 32'd0);
        step();
        check("rd_valid", {31'd0, bus.l2_valid}, 32'd1);
        check("rd_cmd",   {30'd0, bus.l2_cmd},   32'd1);
        check("rd_add",   {6'd0,  bus.l2_add},   32'h0ABCDE);
        check("rd_src",   {31'd0, bus.l2_src},   32'd0);
        step();
        check("rd_done_valid", {31'd0, bus.l2_valid}, 32'd0);
        check("rd_done_cmd",   {30'd0, bus.l2_cmd},   32'd0);
        check("rd_done_add",   {6'd0,  bus.l2_add},   32'd0);

        // Tie arbitration: D0 I0 D1 I1 D2 I2
        do_reset();
        bus.l2_ready = 1'b1;
        bus.d_cmd = 2'b01; bus.d_add = 26'h100;
        bus.i_cmd = 2'b10; bus.i_add = 26'h200;
        step();
        for (int j = 0; j < 6; j++) begin
            if (j < 2) begin
                bus.d_cmd = 2'b01; bus.d_add = 26'h101 + 26'(j);
                bus.i_cmd = 2'b10; bus.i_add = 26'h201 + 26'(j);
            end else begin
                bus.d_cmd = 2'b00;
                bus.i_cmd = 2'b00;
            end
            step();
            check("tie_valid", {31'd0, bus.l2_valid}, 32'd1);
            check("tie_src",   {31'd0, bus.l2_src},   32'(j % 2));
            check("tie_cmd",   {30'd0, bus.l2_cmd},   (j % 2 == 1) ? 32'd2 : 32'd1);
            check("tie_add",   {6'd0,  bus.l2_add},
                  ((j % 2 == 1) ? 32'h200 : 32'h100) + 32'(j / 2));
        end
        step();
        check("tie_end_valid", {31'd0, bus.l2_valid}, 32'd0);
`ifdef ARB_STATS_EN
        check("tie_d_grants", d_grants, 32'd3);
        check("tie_i_grants", i_grants, 32'd3);
`endif

        // Fill and drop: addr 1 in output register, 2..5 fill FIFO, 6 dropped
        do_reset();
        bus.l2_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.d_cmd = 2'b01;
            bus.d_add = 26'(k);
            step();
        end
        check("fill_dfull", {31'd0, bus.d_full},   32'd1);
        check("fill_ifull", {31'd0, bus.i_full},   32'd0);
        check("fill_head",  {6'd0,  bus.l2_add},   32'd1);
        check("fill_valid", {31'd0, bus.l2_valid}, 32'd1);
        bus.d_add = 26'd6;
        step();
        bus.d_cmd    = 2'b00;
        bus.l2_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check("drain_valid", {31'd0, bus.l2_valid}, 32'd1);
            check("drain_add",   {6'd0,  bus.l2_add},   32'(k));
            step();
        end
        check("drain_end_valid", {31'd0, bus.l2_valid}, 32'd0);
        check("drain_dfull",     {31'd0, bus.d_full},   32'd0);

        // Stall: 7 edges with valid high and ready low
        do_reset();
        bus.l2_ready = 1'b0;
        bus.i_cmd = 2'b10;
        bus.i_add = 26'h3FFFFFF;
        step();
        bus.i_cmd = 2'b00;
        step();
        check("stall_valid0", {31'd0, bus.l2_valid}, 32'd1);
        check("stall_src0",   {31'd0, bus.l2_src},   32'd1);
        held_cmd = 2'b10;
        held_add = 26'h3FFFFFF;
        repeat (7) begin
            step();
            check("stall_valid", {31'd0, bus.l2_valid}, 32'd1);
            check("stall_cmd",   {30'd0, bus.l2_cmd},   {30'd0, held_cmd});
            check("stall_add",   {6'd0,  bus.l2_add},   {6'd0, held_add});
        end
`ifdef ARB_STATS_EN
        check("stall_count", stall_cycles, 32'd7);
`endif
        bus.l2_ready = 1'b1;
        step();
        check("stall_done_valid", {31'd0, bus.l2_valid}, 32'd0);

        // Mid-operation reset with three requests queued
        bus.l2_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.d_cmd = 2'b01;
            bus.d_add = 26'h10 + 26'(k);
            step();
        end
        bus.d_cmd = 2'b00;
        check("mr_pre_valid", {31'd0, bus.l2_valid}, 32'd1);
        bus.l2_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_valid", {31'd0, bus.l2_valid}, 32'd0);
        check("mr_cmd",   {30'd0, bus.l2_cmd},   32'd0);
        check("mr_add",   {6'd0,  bus.l2_add},   32'd0);
        repeat (4) begin
            step();
            check("mr_stay_idle", {31'd0, bus.l2_valid}, 32'd0);
        end
`ifdef ARB_STATS_EN
        check("mr_d_grants", d_grants, 32'd0);
`endif

        // Reserved command is never enqueued
        bus.i_cmd = 2'b11;
        bus.i_add = 26'h55;
        repeat (5) step();
        bus.i_cmd = 2'b00;
        step();
        step();
        check("rsvd_valid", {31'd0, bus.l2_valid}, 32'd0);
        check("rsvd_ifull", {31'd0, bus.i_full},   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
